// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> 16-bit instruction-memory writes.
// Holds the core in reset until a frame verifies. Define LOADER_TIMEOUT_EN for the idle watchdog.
module prog_loader #(
    parameter int unsigned ADDRESS_WIDTH     = 4,
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         reload,
    output logic                         imem_we,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] imem_wdata,
    output logic                         core_rst,
    output logic                         done,
    output logic                         error,
    output logic [ADDRESS_WIDTH-1:0]     loaded_count
);

    localparam int unsigned MaxInstr = 2 ** (ADDRESS_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadHi,
        StLoadLo,
        StCheck,
        StRun,
        StError
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] count_n;
    logic [ADDRESS_WIDTH-1:0] index;
    logic [ADDRESS_WIDTH-1:0] index_inc;
    logic [7:0]               hi_byte;
    logic [7:0]               csum;
    logic                     xfer;
    logic                     loading;
    logic                     timeout;
    logic                     bad_header;

    // Ready is a pure decode of the state register, never of in_valid.
    assign in_ready   = (state != StRun) && (state != StError);
    assign loading    = (state == StLoadHi) || (state == StLoadLo) || (state == StCheck);
    assign xfer       = in_valid && in_ready;
    assign index_inc  = index + ADDRESS_WIDTH'(1);
    assign bad_header = (in_data == 8'd0) || (32'(in_data) > MaxInstr);

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [TimerWidth-1:0] idle_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cycles <= '0;
        end else if (!loading || xfer) begin
            idle_cycles <= '0;
        end else begin
            idle_cycles <= idle_cycles + TimerWidth'(1);
        end
    end

    assign timeout = loading && !xfer && (idle_cycles == TimerWidth'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the idle limit has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            count_n      <= '0;
            index        <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            loaded_count <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (xfer) begin
                        if (bad_header) begin
                            state <= StError;
                            error <= 1'b1;
                        end else begin
                            count_n      <= in_data[ADDRESS_WIDTH-1:0];
                            index        <= '0;
                            loaded_count <= '0;
                            csum         <= in_data;
                            state        <= StLoadHi;
                        end
                    end
                end
                StLoadHi: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        csum    <= csum ^ in_data;
                        state   <= StLoadLo;
                    end
                end
                StLoadLo: begin
                    if (xfer) begin
                        csum         <= csum ^ in_data;
                        imem_we      <= 1'b1;
                        imem_addr    <= {index[ADDRESS_WIDTH-2:0], 1'b0};
                        imem_wdata   <= {hi_byte, in_data};
                        loaded_count <= index_inc;
                        index        <= index_inc;
                        state        <= (index_inc == count_n) ? StCheck : StLoadHi;
                    end
                end
                StCheck: begin
                    if (xfer) begin
                        if (in_data == csum) begin
                            state    <= StRun;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= StError;
                            error <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (reload) begin
                        state        <= StIdle;
                        done         <= 1'b0;
                        core_rst     <= 1'b1;
                        loaded_count <= '0;
                    end
                end
                StError: begin
                    if (reload) begin
                        state        <= StIdle;
                        error        <= 1'b0;
                        loaded_count <= '0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
            // A stalled stream overrides whatever the load states decided.
            if (timeout) begin
                state <= StError;
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frame table, hand sequences, random frames
// checked against a frame-level reference model.
module tb_prog_loader;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          core_rst;
    logic          done;
    logic          error;
    logic [AW-1:0] loaded_count;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDRESS_WIDTH(AW),
        .INSTRUCTION_WIDTH(16),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .reload(reload),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .done(done),
        .error(error),
        .loaded_count(loaded_count)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame[$];
    logic [23:0] wr_q[$];  // {loaded_count, addr, data}

    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back({loaded_count, imem_addr, imem_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !sent; t++) begin
            sent = (in_ready === 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("handshake", 32'(sent), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check($sformatf("%s in_ready", tag), 32'(in_ready), 32'd1);
        check($sformatf("%s core_rst", tag), 32'(core_rst), 32'd1);
        check($sformatf("%s done", tag), 32'(done), 32'd0);
        check($sformatf("%s error", tag), 32'(error), 32'd0);
        check($sformatf("%s loaded_count", tag), 32'(loaded_count), 32'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_idle("after reload");
    endtask

    // Frame-level model: header range rule, then XOR of every frame byte must be zero.
    task automatic model(output bit ok, output int unsigned nw);
        int unsigned n;
        logic [7:0]  x;
        n = frame[0];
        if (n == 0 || n > 2 ** (AW - 1)) begin
            ok = 1'b0;
            nw = 0;
        end else begin
            x = '0;
            for (int i = 0; i < 2 * n + 2; i++) x ^= frame[i];
            ok = (x == 8'h00);
            nw = n;
        end
    endtask

    task automatic build_frame(input int unsigned n, input logic [15:0] base,
                               input logic [15:0] step, input bit bad);
        logic [7:0]  c;
        logic [15:0] w;
        frame.delete();
        frame.push_back(8'(n));
        c = 8'(n);
        if (n >= 1 && n <= 8) begin
            for (int i = 0; i < n; i++) begin
                w = base + 16'(i) * step;
                frame.push_back(w[15:8]);
                frame.push_back(w[7:0]);
                c ^= w[15:8] ^ w[7:0];
            end
        end
        if (bad) c ^= 8'h01;
        frame.push_back(c);
    endtask

    task automatic run_frame(input string tag, input bit exp_ok, input int unsigned exp_wr,
                             input int reload_at);
        int unsigned n_acc;
        int unsigned lim;
        logic [23:0] exp_w;
        n_acc = (exp_wr == 0) ? 1 : 2 * exp_wr + 2;
        wr_q.delete();
        for (int i = 0; i < n_acc; i++) begin
            if (i == reload_at) begin
                reload = 1'b1;
                @(negedge clk);
                reload = 1'b0;
            end
            send_byte(frame[i]);
        end
        repeat (2) @(negedge clk);
        check($sformatf("%s done", tag), 32'(done), 32'(exp_ok));
        check($sformatf("%s error", tag), 32'(error), 32'(!exp_ok));
        check($sformatf("%s core_rst", tag), 32'(core_rst), 32'(!exp_ok));
        check($sformatf("%s in_ready", tag), 32'(in_ready), 32'd0);
        check($sformatf("%s loaded_count", tag), 32'(loaded_count), 32'(exp_wr));
        check($sformatf("%s write count", tag), 32'(wr_q.size()), 32'(exp_wr));
        lim = (wr_q.size() < exp_wr) ? wr_q.size() : exp_wr;
        for (int k = 0; k < lim; k++) begin
            exp_w = {4'(k + 1), 4'((2 * k) % 16), frame[1 + 2 * k], frame[2 + 2 * k]};
            check($sformatf("%s write %0d", tag, k), 32'(wr_q[k]), 32'(exp_w));
        end
    endtask

    typedef struct {
        int unsigned n;
        logic [15:0] base;
        logic [15:0] step;
        bit          bad_csum;
        int          reload_at;
        bit          exp_done;
        int unsigned exp_writes;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int unsigned nw;
        int unsigned n;
        logic [7:0]  c;
        logic [7:0]  b;

        vecs[0] = '{2,   16'h1234, 16'h4444, 1'b0, -1, 1'b1, 2};
        vecs[1] = '{2,   16'h1234, 16'h4444, 1'b1, -1, 1'b0, 2};
        vecs[2] = '{0,   16'h0000, 16'h0000, 1'b0, -1, 1'b0, 0};
        vecs[3] = '{9,   16'h0000, 16'h0000, 1'b0, -1, 1'b0, 0};
        vecs[4] = '{8,   16'h0100, 16'h0202, 1'b0, -1, 1'b1, 8};
        vecs[5] = '{1,   16'hABCD, 16'h0000, 1'b0, -1, 1'b1, 1};
        vecs[6] = '{8,   16'hF00F, 16'h1111, 1'b1, -1, 1'b0, 8};
        vecs[7] = '{255, 16'h0000, 16'h0000, 1'b0, -1, 1'b0, 0};
        vecs[8] = '{3,   16'h0A0B, 16'h0101, 1'b0, 2,  1'b1, 3};

        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset imem_we", 32'(imem_we), 32'd0);
        check("reset imem_addr", 32'(imem_addr), 32'd0);
        check("reset imem_wdata", 32'(imem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            build_frame(vecs[v].n, vecs[v].base, vecs[v].step, vecs[v].bad_csum);
            run_frame($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_writes,
                      vecs[v].reload_at);
            do_reload();
        end

        // Reload and a valid byte together in RUN: reload wins, byte is not taken.
        build_frame(1, 16'h5A5A, 16'h0000, 1'b0);
        run_frame("pre-collide", 1'b1, 1, -1);
        in_data  = 8'h01;
        in_valid = 1'b1;
        reload   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b0;
        check_idle("collide");
        build_frame(2, 16'hC001, 16'h0110, 1'b0);
        run_frame("post-collide", 1'b1, 2, -1);
        do_reload();

        // Asynchronous reset mid-frame, after the first HI byte of the second instruction.
        frame = '{8'h02, 8'h12, 8'h34, 8'h56};
        for (int i = 0; i < 4; i++) send_byte(frame[i]);
        check("mid-frame loaded_count", 32'(loaded_count), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle("async rst");
        check("async rst imem_we", 32'(imem_we), 32'd0);
        check("async rst imem_addr", 32'(imem_addr), 32'd0);
        check("async rst imem_wdata", 32'(imem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        build_frame(2, 16'h1234, 16'h4444, 1'b0);
        run_frame("after rst", 1'b1, 2, -1);
        do_reload();

        // Long stall inside a frame: watchdog fires only when compiled in.
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (300) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        check("stall error", 32'(error), 32'd1);
        check("stall core_rst", 32'(core_rst), 32'd1);
        check("stall in_ready", 32'(in_ready), 32'd0);
        do_reload();
`else
        check("stall error", 32'(error), 32'd0);
        check("stall in_ready", 32'(in_ready), 32'd1);
        send_byte(8'h34);
        send_byte(8'h01 ^ 8'h12 ^ 8'h34);
        repeat (2) @(negedge clk);
        check("stall done", 32'(done), 32'd1);
        check("stall core_rst", 32'(core_rst), 32'd0);
        do_reload();
`endif

        for (int r = 0; r < 16; r++) begin
            n = $urandom_range(0, 10);
            frame.delete();
            frame.push_back(8'(n));
            c = 8'(n);
            if (n >= 1 && n <= 8) begin
                for (int i = 0; i < 2 * n; i++) begin
                    b = 8'($urandom);
                    frame.push_back(b);
                    c ^= b;
                end
            end
            if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
            frame.push_back(c);
            model(ok, nw);
            run_frame($sformatf("rand%0d", r), ok, nw, -1);
            do_reload();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
